// File: rtl/tau_mem_pkg.sv
// Shared types for the memory sequencer: the request opcode set and the FSM
// state encoding.
package tau_mem_pkg;

    typedef enum logic [2:0] {
        OpLoad   = 3'd1,
        OpStore  = 3'd2,
        OpLoadV  = 3'd3,
        OpStoreV = 3'd4,
        OpPeek   = 3'd5
    } load_store_op_set;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StWait,
        StRespond
    } seq_state_e;

    localparam int unsigned LatCntWidth = 4;

endpackage

// File: rtl/mem_latency_counter.sv
// Loadable down-counter that times the read wait; done_o is high while the
// count sits at zero.
module mem_latency_counter #(
    parameter int unsigned Width = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [Width-1:0] load_value_i,
    input  logic             dec_i,
    output logic             done_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_value_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/memory_sequencer.sv
// Single-request sequencer that turns LOAD/STORE/LOADV/STOREV/PEEK requests into
// one program- or variable-RAM access and returns a one-cycle response.
module memory_sequencer
    import tau_mem_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 16,
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned RAM_LATENCY   = 1,
    parameter int unsigned PEEK_OFFSET   = 1,
    parameter int unsigned V_RAM_DEPTH   = 2 ** ADDRESS_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [2:0]               op,
    input  logic [ADDRESS_WIDTH-1:0] pc_address,
    input  logic [ADDRESS_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    output logic                     p_ram_en,
    output logic                     p_ram_rw,
    output logic [ADDRESS_WIDTH-1:0] p_ram_address,
    output logic [DATA_WIDTH-1:0]    p_ram_wdata,
    input  logic [DATA_WIDTH-1:0]    p_ram_rdata,
    output logic                     v_ram_en,
    output logic                     v_ram_rw,
    output logic [ADDRESS_WIDTH-1:0] v_ram_address,
    output logic [DATA_WIDTH-1:0]    v_ram_wdata,
    input  logic [DATA_WIDTH-1:0]    v_ram_rdata,
    output logic                     rsp_valid,
    output logic [DATA_WIDTH-1:0]    rsp_data,
    output logic                     rsp_error
);

    localparam logic [ADDRESS_WIDTH:0]     VDepth   = (ADDRESS_WIDTH + 1)'(V_RAM_DEPTH);
    localparam logic [ADDRESS_WIDTH-1:0]   PeekOff  = ADDRESS_WIDTH'(PEEK_OFFSET);
    localparam logic [LatCntWidth-1:0]     WaitLoad = LatCntWidth'(RAM_LATENCY - 1);

    seq_state_e state_q, state_d;
    logic is_read_q, is_read_d;
    logic sel_v_q, sel_v_d;
    logic p_en_q, p_en_d, p_rw_q, p_rw_d;
    logic v_en_q, v_en_d, v_rw_q, v_rw_d;
    logic [ADDRESS_WIDTH-1:0] p_addr_q, p_addr_d, v_addr_q, v_addr_d;
    logic [DATA_WIDTH-1:0]    p_wdata_q, p_wdata_d, v_wdata_q, v_wdata_d;
    logic rsp_valid_q, rsp_valid_d, rsp_error_q, rsp_error_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

    logic                     dec_err, dec_v, dec_wr, addr_oor;
    logic [ADDRESS_WIDTH-1:0] dec_addr;
    logic                     cnt_load, cnt_done, accept;

    assign req_ready = !reset && (state_q == StIdle);
    assign accept    = req_valid && req_ready;
    assign addr_oor  = ({1'b0, address} >= VDepth);

    always_comb begin
        dec_err  = 1'b0;
        dec_v    = 1'b0;
        dec_wr   = 1'b0;
        dec_addr = address;
        case (op)
            OpLoad:   ;
            OpStore:  dec_wr = 1'b1;
            OpLoadV: begin
                dec_v   = 1'b1;
                dec_err = addr_oor;
            end
            OpStoreV: begin
                dec_v   = 1'b1;
                dec_wr  = 1'b1;
                dec_err = addr_oor;
            end
            OpPeek:   dec_addr = pc_address + PeekOff;
            default:  dec_err = 1'b1;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        is_read_d   = is_read_q;
        sel_v_d     = sel_v_q;
        p_en_d      = 1'b0;
        p_rw_d      = 1'b0;
        v_en_d      = 1'b0;
        v_rw_d      = 1'b0;
        p_addr_d    = p_addr_q;
        p_wdata_d   = p_wdata_q;
        v_addr_d    = v_addr_q;
        v_wdata_d   = v_wdata_q;
        rsp_valid_d = 1'b0;
        rsp_error_d = rsp_error_q;
        rsp_data_d  = rsp_data_q;
        cnt_load    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (dec_err) begin
                        state_d     = StRespond;
                        rsp_valid_d = 1'b1;
                        rsp_error_d = 1'b1;
                        rsp_data_d  = '0;
                    end else begin
                        state_d   = StAccess;
                        is_read_d = !dec_wr;
                        sel_v_d   = dec_v;
                        if (dec_v) begin
                            v_en_d   = 1'b1;
                            v_rw_d   = dec_wr;
                            v_addr_d = dec_addr;
                            if (dec_wr) v_wdata_d = wr_data;
                        end else begin
                            p_en_d   = 1'b1;
                            p_rw_d   = dec_wr;
                            p_addr_d = dec_addr;
                            if (dec_wr) p_wdata_d = wr_data;
                        end
                    end
                end
            end
            StAccess: begin
                if (is_read_q) begin
                    state_d  = StWait;
                    cnt_load = 1'b1;
                end else begin
                    state_d     = StRespond;
                    rsp_valid_d = 1'b1;
                    rsp_error_d = 1'b0;
                    rsp_data_d  = '0;
                end
            end
            StWait: begin
                // The last WAIT cycle is the one in which read data is valid.
                if (cnt_done) begin
                    state_d     = StRespond;
                    rsp_valid_d = 1'b1;
                    rsp_error_d = 1'b0;
                    rsp_data_d  = sel_v_q ? v_ram_rdata : p_ram_rdata;
                end
            end
            StRespond: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            is_read_q   <= 1'b0;
            sel_v_q     <= 1'b0;
            p_en_q      <= 1'b0;
            p_rw_q      <= 1'b0;
            v_en_q      <= 1'b0;
            v_rw_q      <= 1'b0;
            p_addr_q    <= '0;
            p_wdata_q   <= '0;
            v_addr_q    <= '0;
            v_wdata_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            is_read_q   <= is_read_d;
            sel_v_q     <= sel_v_d;
            p_en_q      <= p_en_d;
            p_rw_q      <= p_rw_d;
            v_en_q      <= v_en_d;
            v_rw_q      <= v_rw_d;
            p_addr_q    <= p_addr_d;
            p_wdata_q   <= p_wdata_d;
            v_addr_q    <= v_addr_d;
            v_wdata_q   <= v_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_error_q <= rsp_error_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    mem_latency_counter #(
        .Width(LatCntWidth)
    ) u_lat_cnt (
        .clk         (clk),
        .reset       (reset),
        .load_i      (cnt_load),
        .load_value_i(WaitLoad),
        .dec_i       (state_q == StWait),
        .done_o      (cnt_done)
    );

    assign p_ram_en      = p_en_q;
    assign p_ram_rw      = p_rw_q;
    assign p_ram_address = p_addr_q;
    assign p_ram_wdata   = p_wdata_q;
    assign v_ram_en      = v_en_q;
    assign v_ram_rw      = v_rw_q;
    assign v_ram_address = v_addr_q;
    assign v_ram_wdata   = v_wdata_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = rsp_data_q;
    assign rsp_error     = rsp_error_q;

endmodule

// File: tb/tb_memory_sequencer.sv
// Self-checking bench for memory_sequencer: directed vector table, hand-written
// reset/back-to-back sequences, and random requests against a request-level model.
module tb_memory_sequencer;

    localparam int LAT    = 3;
    localparam int VDEPTH = 256;
    localparam int POFF   = 1;

    logic        clk, reset, req_valid, req_ready;
    logic [2:0]  op;
    logic [15:0] pc_address, address, wr_data;
    logic        p_ram_en, p_ram_rw, v_ram_en, v_ram_rw;
    logic [15:0] p_ram_address, p_ram_wdata, p_ram_rdata;
    logic [15:0] v_ram_address, v_ram_wdata, v_ram_rdata;
    logic        rsp_valid, rsp_error;
    logic [15:0] rsp_data;

    int n_cmp = 0;
    int n_bad = 0;

    memory_sequencer #(
        .ADDRESS_WIDTH(16),
        .DATA_WIDTH   (16),
        .RAM_LATENCY  (LAT),
        .PEEK_OFFSET  (POFF),
        .V_RAM_DEPTH  (VDEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .op           (op),
        .pc_address   (pc_address),
        .address      (address),
        .wr_data      (wr_data),
        .p_ram_en     (p_ram_en),
        .p_ram_rw     (p_ram_rw),
        .p_ram_address(p_ram_address),
        .p_ram_wdata  (p_ram_wdata),
        .p_ram_rdata  (p_ram_rdata),
        .v_ram_en     (v_ram_en),
        .v_ram_rw     (v_ram_rw),
        .v_ram_address(v_ram_address),
        .v_ram_wdata  (v_ram_wdata),
        .v_ram_rdata  (v_ram_rdata),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .rsp_error    (rsp_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM contents seen by the DUT, and the model's own shadow copy.
    logic [15:0] ram_p [65536];
    logic [15:0] ram_v [VDEPTH];
    logic [15:0] ref_p [65536];
    logic [15:0] ref_v [VDEPTH];

    // RAMs: read data is valid exactly LAT cycles after the enable cycle.
    int p_left, v_left;
    logic p_pend = 1'b0, v_pend = 1'b0;
    logic [15:0] p_a, v_a;
    always @(negedge clk) begin
        if (p_ram_en && p_ram_rw) ram_p[p_ram_address] = p_ram_wdata;
        if (p_ram_en && !p_ram_rw) begin
            p_pend = 1'b1; p_left = LAT; p_a = p_ram_address;
        end else if (p_pend) p_left--;
        if (p_pend && p_left == 0) begin
            p_ram_rdata = ram_p[p_a]; p_pend = 1'b0;
        end else p_ram_rdata = 16'($urandom);

        if (v_ram_en && v_ram_rw) ram_v[v_ram_address[7:0]] = v_ram_wdata;
        if (v_ram_en && !v_ram_rw) begin
            v_pend = 1'b1; v_left = LAT; v_a = v_ram_address;
        end else if (v_pend) v_left--;
        if (v_pend && v_left == 0) begin
            v_ram_rdata = ram_v[v_a[7:0]]; v_pend = 1'b0;
        end else v_ram_rdata = 16'($urandom);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Request-level model: what the sequencer must do for one request.
    function automatic void model(input logic [2:0] m_op, input logic [15:0] m_addr,
                                  input logic [15:0] m_pc, output logic e_err,
                                  output int e_lat, output int e_sel,
                                  output logic [15:0] e_raddr, output logic e_rw,
                                  output logic [15:0] e_data);
        int peek;
        e_err = 1'b0; e_lat = 1; e_sel = 0; e_raddr = 16'h0; e_rw = 1'b0; e_data = 16'h0;
        peek = (int'(m_pc) + POFF) % 65536;
        case (m_op)
            3'd1: begin e_sel = 1; e_raddr = m_addr; end
            3'd2: begin e_sel = 1; e_raddr = m_addr; e_rw = 1'b1; end
            3'd3: begin e_sel = 2; e_raddr = m_addr; end
            3'd4: begin e_sel = 2; e_raddr = m_addr; e_rw = 1'b1; end
            3'd5: begin e_sel = 1; e_raddr = 16'(peek); end
            default: e_err = 1'b1;
        endcase
        if (e_sel == 2 && int'(m_addr) >= VDEPTH) begin
            e_err = 1'b1; e_sel = 0; e_raddr = 16'h0; e_rw = 1'b0;
        end
        if (!e_err) begin
            e_lat = e_rw ? 2 : LAT + 2;
            if (!e_rw) e_data = (e_sel == 1) ? ref_p[e_raddr] : ref_v[e_raddr[7:0]];
        end
    endfunction

    // Entered and left at #1 after a posedge with the DUT idle.
    task automatic run_txn(input string nm, input logic [2:0] t_op, input logic [15:0] t_addr,
                           input logic [15:0] t_pc, input logic [15:0] t_wd,
                           input logic e_err, input int e_lat, input int e_sel,
                           input logic [15:0] e_raddr, input logic e_rw,
                           input logic [15:0] e_data);
        int lat = 0, p_cnt = 0, v_cnt = 0, en_cyc = 0, stray = 0, busy = 0;
        logic [15:0] g_addr = 16'h0, g_wd = 16'h0;
        logic g_rw = 1'b0;
        chk({nm, " ready before"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; op = t_op; address = t_addr; pc_address = t_pc; wr_data = t_wd;
        @(posedge clk); #1;
        req_valid = 1'b0; op = 3'($urandom); address = 16'($urandom);
        pc_address = 16'($urandom); wr_data = 16'($urandom);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (p_ram_en) begin
                p_cnt++; en_cyc = k; g_addr = p_ram_address; g_rw = p_ram_rw; g_wd = p_ram_wdata;
            end
            if (v_ram_en) begin
                v_cnt++; en_cyc = k; g_addr = v_ram_address; g_rw = v_ram_rw; g_wd = v_ram_wdata;
            end
            if ((p_ram_rw && !p_ram_en) || (v_ram_rw && !v_ram_en)) stray++;
            if (req_ready) busy++;
            if (rsp_valid) begin
                lat = k;
                break;
            end
        end
        chk({nm, " latency"}, 32'(lat), 32'(e_lat));
        chk({nm, " rsp_error"}, 32'(rsp_error), 32'(e_err));
        chk({nm, " rsp_data"}, 32'(rsp_data), 32'(e_data));
        chk({nm, " p_en cycles"}, 32'(p_cnt), (e_sel == 1) ? 32'd1 : 32'd0);
        chk({nm, " v_en cycles"}, 32'(v_cnt), (e_sel == 2) ? 32'd1 : 32'd0);
        chk({nm, " rw outside en"}, 32'(stray), 32'd0);
        chk({nm, " ready while busy"}, 32'(busy), 32'd0);
        if (e_sel != 0) begin
            chk({nm, " en cycle"}, 32'(en_cyc), 32'd1);
            chk({nm, " ram addr"}, 32'(g_addr), 32'(e_raddr));
            chk({nm, " ram rw"}, 32'(g_rw), 32'(e_rw));
            if (e_rw) begin
                chk({nm, " ram wdata"}, 32'(g_wd), 32'(t_wd));
                if (e_sel == 1) ref_p[e_raddr] = t_wd;
                else ref_v[e_raddr[7:0]] = t_wd;
            end
        end
        @(posedge clk); #1;
        chk({nm, " valid drops"}, 32'(rsp_valid), 32'd0);
        chk({nm, " data holds"}, 32'(rsp_data), 32'(e_data));
        chk({nm, " error holds"}, 32'(rsp_error), 32'(e_err));
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [15:0] addr, pc, wd;
        logic        err;
        int          lat, sel;
        logic [15:0] raddr;
        logic        rw;
        logic [15:0] data;
    } vec_t;

    vec_t vecs [13];

    task automatic check_all_zero(input string nm);
        chk({nm, " p_en"}, 32'(p_ram_en), 32'd0);
        chk({nm, " p_rw"}, 32'(p_ram_rw), 32'd0);
        chk({nm, " p_addr"}, 32'(p_ram_address), 32'd0);
        chk({nm, " p_wdata"}, 32'(p_ram_wdata), 32'd0);
        chk({nm, " v_en"}, 32'(v_ram_en), 32'd0);
        chk({nm, " v_rw"}, 32'(v_ram_rw), 32'd0);
        chk({nm, " v_addr"}, 32'(v_ram_address), 32'd0);
        chk({nm, " v_wdata"}, 32'(v_ram_wdata), 32'd0);
        chk({nm, " rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({nm, " rsp_data"}, 32'(rsp_data), 32'd0);
        chk({nm, " rsp_error"}, 32'(rsp_error), 32'd0);
        chk({nm, " req_ready"}, 32'(req_ready), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        e_err, e_rw;
        int          e_lat, e_sel;
        logic [15:0] e_raddr, e_data, r_addr, r_pc, r_wd;
        logic [2:0]  r_op;
        int          n_acc, n_en, n_low, n_rsp;
        logic        acc;

        for (int i = 0; i < 65536; i++) begin
            ram_p[i] = 16'($urandom); ref_p[i] = ram_p[i];
        end
        for (int i = 0; i < VDEPTH; i++) begin
            ram_v[i] = 16'($urandom); ref_v[i] = ram_v[i];
        end
        ram_p[16'h0010] = 16'hBEEF; ref_p[16'h0010] = 16'hBEEF;
        ram_p[16'h0000] = 16'hA5A5; ref_p[16'h0000] = 16'hA5A5;

        vecs[0]  = '{3'd1, 16'h0010, 16'h1234, 16'h0000, 1'b0, 5, 1, 16'h0010, 1'b0, 16'hBEEF};
        vecs[1]  = '{3'd4, 16'h0004, 16'h0000, 16'h1234, 1'b0, 2, 2, 16'h0004, 1'b1, 16'h0000};
        vecs[2]  = '{3'd5, 16'h0777, 16'hFFFF, 16'h0000, 1'b0, 5, 1, 16'h0000, 1'b0, 16'hA5A5};
        vecs[3]  = '{3'd6, 16'h0010, 16'h0000, 16'h0000, 1'b1, 1, 0, 16'h0000, 1'b0, 16'h0000};
        vecs[4]  = '{3'd3, 16'h0100, 16'h0000, 16'h0000, 1'b1, 1, 0, 16'h0000, 1'b0, 16'h0000};
        vecs[5]  = '{3'd3, 16'h0004, 16'h0000, 16'h0000, 1'b0, 5, 2, 16'h0004, 1'b0, 16'h1234};
        vecs[6]  = '{3'd2, 16'h0020, 16'h0000, 16'h5678, 1'b0, 2, 1, 16'h0020, 1'b1, 16'h0000};
        vecs[7]  = '{3'd1, 16'h0020, 16'h0000, 16'h0000, 1'b0, 5, 1, 16'h0020, 1'b0, 16'h5678};
        vecs[8]  = '{3'd0, 16'h0005, 16'h0000, 16'h0000, 1'b1, 1, 0, 16'h0000, 1'b0, 16'h0000};
        vecs[9]  = '{3'd4, 16'h00FF, 16'h0000, 16'h0BAD, 1'b0, 2, 2, 16'h00FF, 1'b1, 16'h0000};
        vecs[10] = '{3'd4, 16'h0100, 16'h0000, 16'h1111, 1'b1, 1, 0, 16'h0000, 1'b0, 16'h0000};
        vecs[11] = '{3'd5, 16'h0000, 16'h001F, 16'h0000, 1'b0, 5, 1, 16'h0020, 1'b0, 16'h5678};
        vecs[12] = '{3'd7, 16'h0001, 16'h0000, 16'h0000, 1'b1, 1, 0, 16'h0000, 1'b0, 16'h0000};

        reset = 1'b1; req_valid = 1'b0; op = 3'd0;
        address = 16'h0; pc_address = 16'h0; wr_data = 16'h0;
        @(posedge clk); @(posedge clk); #1;
        check_all_zero("in reset");
        reset = 1'b0;
        @(negedge clk);
        chk("ready after release", 32'(req_ready), 32'd1);
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            run_txn($sformatf("vec%0d", i), vecs[i].op, vecs[i].addr, vecs[i].pc, vecs[i].wd,
                    vecs[i].err, vecs[i].lat, vecs[i].sel, vecs[i].raddr, vecs[i].rw,
                    vecs[i].data);
        end

        // Back-to-back STOREs with req_valid held high.
        n_acc = 0; n_en = 0; n_low = 0; n_rsp = 0;
        req_valid = 1'b1; op = 3'd2; address = 16'h0300; wr_data = 16'hC000;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (p_ram_en) begin
                chk("b2b en addr", 32'(p_ram_address), 32'(16'h0300 + 16'(n_en)));
                chk("b2b en wdata", 32'(p_ram_wdata), 32'(16'hC000 + 16'(n_en)));
                chk("b2b en rw", 32'(p_ram_rw), 32'd1);
                n_en++;
            end
            if (rsp_valid) n_rsp++;
            acc = req_valid && req_ready;
            if (req_valid && !req_ready) n_low++;
            @(posedge clk); #1;
            if (acc) begin
                n_acc++;
                if (n_acc == 4) req_valid = 1'b0;
                else begin
                    address = 16'h0300 + 16'(n_acc); wr_data = 16'hC000 + 16'(n_acc);
                end
            end
        end
        chk("b2b accepts", 32'(n_acc), 32'd4);
        chk("b2b enables", 32'(n_en), 32'd4);
        chk("b2b responses", 32'(n_rsp), 32'd4);
        chk("b2b ready low cycles", 32'(n_low), 32'd6);
        for (int i = 0; i < 4; i++) ref_p[16'h0300 + 16'(i)] = 16'hC000 + 16'(i);

        for (int n = 0; n < 40; n++) begin
            r_op = 3'($urandom_range(0, 7));
            r_addr = (r_op == 3'd3 || r_op == 3'd4) ? 16'($urandom_range(0, 300))
                                                    : 16'($urandom);
            r_pc = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            r_wd = 16'($urandom);
            model(r_op, r_addr, r_pc, e_err, e_lat, e_sel, e_raddr, e_rw, e_data);
            run_txn($sformatf("rnd%0d", n), r_op, r_addr, r_pc, r_wd,
                    e_err, e_lat, e_sel, e_raddr, e_rw, e_data);
        end

        // Reset during the WAIT phase of a LOAD aborts it silently.
        req_valid = 1'b1; op = 3'd1; address = 16'h0010;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check_all_zero("wait reset");
        reset = 1'b0;
        @(negedge clk);
        chk("wait reset ready", 32'(req_ready), 32'd1);
        n_rsp = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (rsp_valid || p_ram_en) n_rsp++;
        end
        chk("wait reset no response", 32'(n_rsp), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
